cl_uart_txn_arbiter: RTL

Shares the single CameraLink serial UART between two independent requesters: the CPU command path behind the AXI bridge (port 0) and the autonomous camera-configuration engine (port 1). It grants the UART for a whole command frame, paces bytes against the UART's `tx_busy`, and collects the camera's reply bytes. It routes those bytes back to the frame owner and enforces a reply timeout. It sits between the requesters and the CameraLink UART core.

---
 rtl/cl_uart_txn_arbiter.sv | 249 ++++++++++++++++++++++++
 1 files changed

// File: rtl/cl_uart_txn_arbiter.sv
// rtl/cl_uart_txn_arbiter.sv - two-port frame arbiter for the CameraLink serial UART
//
// Purpose:
//   Shares one CameraLink UART between the CPU command path (port 0) and the
//   camera-configuration engine (port 1). A port owns the UART for a whole
//   command frame. Bytes are paced against tx_busy, and reply bytes are routed
//   back to the owner under an inter-byte reply timeout.
//
// Ports:
//   s_axi_aclk, s_axi_areset        clock, synchronous active-high reset
//   reqN_valid/data/last/resp_len   byte stream from requester N (N = 0, 1)
//   reqN_ready                      byte accepted when valid && ready
//   rspN_valid                      reply byte for port N on rsp_data
//   rspN_done                       frame of port N finished, rsp_status valid
//   rsp_data, rsp_status            shared reply byte / completion status
//                                   (00 ok, 01 reply timeout, 10 ack timeout)
//   grant                           one-hot owner of the frame in progress
//   rx_unsolicited                  rx byte dropped outside the reply window
//   tx_start, tx_data, tx_busy      UART transmit side
//   rx_ready, rx_data               UART receive side
module cl_uart_txn_arbiter #(
  parameter int RESP_TIMEOUT   = 1000000,
  parameter int TX_ACK_TIMEOUT = 16
) (
  input  logic       s_axi_aclk,
  input  logic       s_axi_areset,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  input  logic       req0_last,
  input  logic [7:0] req0_resp_len,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  input  logic       req1_last,
  input  logic [7:0] req1_resp_len,
  output logic       req1_ready,
  output logic       rsp0_valid,
  output logic       rsp0_done,
  output logic       rsp1_valid,
  output logic       rsp1_done,
  output logic [7:0] rsp_data,
  output logic [1:0] rsp_status,
  output logic [1:0] grant,
  output logic       rx_unsolicited,
  output logic       tx_start,
  output logic [7:0] tx_data,
  input  logic       tx_busy,
  input  logic       rx_ready,
  input  logic [7:0] rx_data
);

  localparam int TMAX = (RESP_TIMEOUT > TX_ACK_TIMEOUT) ? RESP_TIMEOUT : TX_ACK_TIMEOUT;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] RESP_LOAD = TW'(RESP_TIMEOUT);
  localparam logic [TW-1:0] ACK_LOAD  = TW'(TX_ACK_TIMEOUT);
  localparam logic [TW-1:0] T_ONE     = TW'(1);

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_RSP_TO  = 2'b01;
  localparam logic [1:0] ST_ACK_TO  = 2'b10;

  typedef enum logic [2:0] {IDLE, SEND, WAIT_ACK, WAIT_DONE, RESP_WAIT} state_t;

  state_t          state, state_next;
  logic [1:0]      grant_q, grant_next;
  logic            last_served;      // port index that finished most recently
  logic            first_q;          // next accepted byte opens the frame
  logic            last_q;
  logic [7:0]      resp_len_q;
  logic [7:0]      remaining;
  logic [TW-1:0]   timer;            // shared: ack wait, then reply gap
  logic            tx_start_q;
  logic [7:0]      tx_data_q;
  logic [7:0]      rsp_data_q;
  logic [1:0]      rsp_status_q;
  logic [1:0]      rsp_valid_q;
  logic [1:0]      rsp_done_q;
  logic            rx_unsol_q;

  logic            send_ok, accept;
  logic [7:0]      own_data, own_resp_len;
  logic            own_last;
  logic            done_fire, to_resp, rx_take;
  logic [1:0]      done_code;

  assign send_ok    = (state == SEND) && !tx_busy;
  assign req0_ready = send_ok && grant_q[0];
  assign req1_ready = send_ok && grant_q[1];
  assign accept     = (req0_ready && req0_valid) || (req1_ready && req1_valid);

  assign own_data     = grant_q[1] ? req1_data     : req0_data;
  assign own_last     = grant_q[1] ? req1_last     : req0_last;
  assign own_resp_len = grant_q[1] ? req1_resp_len : req0_resp_len;

  assign grant          = grant_q;
  assign tx_start       = tx_start_q;
  assign tx_data        = tx_data_q;
  assign rsp_data       = rsp_data_q;
  assign rsp_status     = rsp_status_q;
  assign rsp0_valid     = rsp_valid_q[0];
  assign rsp1_valid     = rsp_valid_q[1];
  assign rsp0_done      = rsp_done_q[0];
  assign rsp1_done      = rsp_done_q[1];
  assign rx_unsolicited = rx_unsol_q;

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    grant_next = grant_q;
    done_fire  = 1'b0;
    done_code  = ST_OK;
    to_resp    = 1'b0;
    rx_take    = 1'b0;
    case (state)
      IDLE: begin
        // grant holds through the done cycle and clears (or re-arbitrates) here
        grant_next = 2'b00;
        if (req0_valid && req1_valid) begin
          grant_next = last_served ? 2'b01 : 2'b10;
        end else if (req0_valid) begin
          grant_next = 2'b01;
        end else if (req1_valid) begin
          grant_next = 2'b10;
        end
        if (req0_valid || req1_valid) begin
          state_next = SEND;
        end
      end
      SEND: begin
        if (accept) begin
          state_next = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        // tx_busy seen alongside tx_start may be left over from the previous byte
        if (!tx_start_q) begin
          if (tx_busy) begin
            state_next = WAIT_DONE;
          end else if (timer <= T_ONE) begin
            done_fire  = 1'b1;
            done_code  = ST_ACK_TO;
            state_next = IDLE;
          end
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          if (!last_q) begin
            state_next = SEND;
          end else if (resp_len_q == 8'd0) begin
            done_fire  = 1'b1;
            state_next = IDLE;
          end else begin
            to_resp    = 1'b1;
            state_next = RESP_WAIT;
          end
        end
      end
      RESP_WAIT: begin
        // a byte arriving on the expiry cycle wins over the timeout
        if (rx_ready) begin
          rx_take = 1'b1;
          if (remaining <= 8'd1) begin
            done_fire  = 1'b1;
            state_next = IDLE;
          end
        end else if (timer <= T_ONE) begin
          done_fire  = 1'b1;
          done_code  = ST_RSP_TO;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      grant_q      <= 2'b00;
      last_served  <= 1'b1;
      first_q      <= 1'b0;
      last_q       <= 1'b0;
      resp_len_q   <= 8'd0;
      remaining    <= 8'd0;
      timer        <= '0;
      tx_start_q   <= 1'b0;
      tx_data_q    <= 8'd0;
      rsp_data_q   <= 8'd0;
      rsp_status_q <= ST_OK;
      rsp_valid_q  <= 2'b00;
      rsp_done_q   <= 2'b00;
      rx_unsol_q   <= 1'b0;
    end else begin
      grant_q     <= grant_next;
      tx_start_q  <= accept;
      rsp_valid_q <= 2'b00;
      rsp_done_q  <= 2'b00;
      rx_unsol_q  <= rx_ready && (state != RESP_WAIT);

      if (state == IDLE && state_next == SEND) begin
        first_q <= 1'b1;
      end

      if (accept) begin
        tx_data_q <= own_data;
        last_q    <= own_last;
        timer     <= ACK_LOAD;
        if (first_q) begin
          resp_len_q <= own_resp_len;
          first_q    <= 1'b0;
        end
      end

      if (state == WAIT_ACK && !tx_start_q && timer != '0) begin
        timer <= timer - T_ONE;
      end

      if (to_resp) begin
        remaining <= resp_len_q;
        timer     <= RESP_LOAD;
      end

      if (state == RESP_WAIT) begin
        if (rx_take) begin
          rsp_data_q  <= rx_data;
          rsp_valid_q <= grant_q;
          remaining   <= remaining - 8'd1;
          timer       <= RESP_LOAD;
        end else if (timer != '0) begin
          timer <= timer - T_ONE;
        end
      end

      if (done_fire) begin
        rsp_done_q   <= grant_q;
        rsp_status_q <= done_code;
        last_served  <= grant_q[1];
      end
    end
  end

endmodule
